// File: rtl/sequential_divider_if.sv
// Handshake and result bundle between the ALU controller and the sequential divider.
// The controller owns the request side; the divider owns status and results.
interface sequential_divider_if #(
  parameter int M = 8,
  parameter int N = 4
);
  logic         start;
  logic [M-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [M-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, M steps per division.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module sequential_divider #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  sequential_divider_if.slave bus
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [M-1:0]   dvd;        // dividend bits shift out the top, quotient bits shift in the bottom
  logic [N-1:0]   rem;        // stays below the divisor, so N bits are enough between steps
  logic [N-1:0]   dsr;
  logic [CW-1:0]  cnt;

  logic [N:0]     rem_shift;
  logic [N:0]     rem_step;
  logic           q_bit;

  logic [M-1:0]   q_r;
  logic [N-1:0]   r_r;
  logic           dbz_r;

  // One restoring step on the current shift-register contents.
  always_comb begin
    rem_shift = {rem, dvd[M-1]};
    q_bit     = (rem_shift >= {1'b0, dsr});
    rem_step  = q_bit ? (rem_shift - {1'b0, dsr}) : rem_shift;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.B == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.B == '0) begin
              q_r   <= '1;
              r_r   <= '0;
              dbz_r <= 1'b1;
            end else begin
              dvd   <= bus.A;
              dsr   <= bus.B;
              rem   <= '0;
              cnt   <= CW'(M - 1);
              dbz_r <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[M-2:0], q_bit};
          rem <= rem_step[N-1:0];
          cnt <= cnt - CW'(1);
          // Results are published only on the final step so Q/R hold the previous answer until then.
          if (cnt == '0) begin
            q_r <= {dvd[M-2:0], q_bit};
            r_r <= rem_step[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed vector table, multi-cycle corner
// sequences, and an exhaustive plus random sweep against an arithmetic reference model.
module tb_sequential_divider;

  localparam int M = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sequential_divider_if #(.M(M), .N(N)) dif ();

  sequential_divider #(.M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones quotient.
  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << M) - 1;
      r = 0;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Waits (bounded) for done, sampling at negedges; lat = edges after the accepting edge.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_accept", int'(dif.busy), 1);
      if (dif.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) $display("FAIL done_timeout: got no done within 40 cycles, expected done");
  endtask

  task automatic run_div(input int a, input int b, output int lat);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A     = M'(a);
    dif.B     = N'(b);
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_div(input int a, input int b);
    int lat, q, r, z;
    model(a, b, q, r, z);
    run_div(a, b, lat);
    check("latency", lat, (b == 0) ? 0 : M);
    check("Q", int'(dif.Q), q);
    check("R", int'(dif.R), r);
    check("div_by_zero", int'(dif.div_by_zero), z);
    if (b != 0) begin
      check("identity", int'(dif.Q) * b + int'(dif.R), a);
      check("r_lt_b", int'(int'(dif.R) < b), 1);
    end
    @(negedge clk);
    check("done_one_cycle", int'(dif.done), 0);
    check("busy_falls", int'(dif.busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   seen;

    vecs[0] = '{a: 200, b: 7,  q: 28,  r: 4, z: 0};
    vecs[1] = '{a: 255, b: 15, q: 17,  r: 0, z: 0};
    vecs[2] = '{a: 5,   b: 9,  q: 0,   r: 5, z: 0};
    vecs[3] = '{a: 0,   b: 1,  q: 0,   r: 0, z: 0};
    vecs[4] = '{a: 99,  b: 0,  q: 255, r: 0, z: 1};
    vecs[5] = '{a: 10,  b: 3,  q: 3,   r: 1, z: 0};

    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(dif.busy), 0);
    check("reset_done", int'(dif.done), 0);
    check("reset_Q", int'(dif.Q), 0);
    check("reset_R", int'(dif.R), 0);
    check("reset_dbz", int'(dif.div_by_zero), 0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check("tbl_latency", lat, (vecs[i].b == 0) ? 0 : M);
      check("tbl_Q", int'(dif.Q), vecs[i].q);
      check("tbl_R", int'(dif.R), vecs[i].r);
      check("tbl_dbz", int'(dif.div_by_zero), vecs[i].z);
      @(negedge clk);
      check("tbl_done_pulse", int'(dif.done), 0);
    end

    // start held during CALC must be ignored, then launches 1/1 from the next IDLE
    @(negedge clk);
    dif.start = 1'b1;
    dif.A     = 8'd200;
    dif.B     = 4'd7;
    @(posedge clk);
    #1;
    dif.A = 8'd1;
    dif.B = 4'd1;
    wait_done(lat);
    check("held_latency", lat, M);
    check("held_Q", int'(dif.Q), 28);
    check("held_R", int'(dif.R), 4);
    @(posedge clk);
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_done(lat);
    check("relaunch_latency", lat, M);
    check("relaunch_Q", int'(dif.Q), 1);
    check("relaunch_R", int'(dif.R), 0);
    @(negedge clk);

    // Reset in the 4th CALC cycle aborts without a done pulse
    @(negedge clk);
    dif.start = 1'b1;
    dif.A     = 8'd200;
    dif.B     = 4'd7;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(dif.busy), 0);
    check("abort_Q", int'(dif.Q), 0);
    check("abort_R", int'(dif.R), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dif.done) seen = 1;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    check_div(200, 7);

    // Reset and start together: reset wins
    @(negedge clk);
    rst       = 1'b1;
    dif.start = 1'b1;
    dif.A     = 8'd10;
    dif.B     = 4'd3;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(dif.busy), 0);
    check("rst_start_Q", int'(dif.Q), 0);

    // Exhaustive operand sweep
    for (int a = 0; a < (1 << M); a++)
      for (int b = 0; b < (1 << N); b++)
        check_div(a, b);

    // Random operands, including back-to-back reuse of the idle cycle
    for (int k = 0; k < 300; k++)
      check_div(int'($urandom_range((1 << M) - 1)), int'($urandom_range((1 << N) - 1)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
